// File: rtl/jk_flipflop_bank.sv
`default_nettype none
// ============================================================================
//  Module   : jk_flipflop_bank
//  Brief    : Bank of WIDTH edge-triggered JK flip-flops with complementary
//             outputs. Supports per-bit JK, parallel load, and up/down
//             counting built from JK toggle chains.
//  Revision : 1.0 - initial release
// ============================================================================
module jk_flipflop_bank #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,   // asynchronous, active-low
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc
);

    localparam logic [1:0] c_MODE_JK   = 2'b00;
    localparam logic [1:0] c_MODE_LOAD = 2'b01;
    localparam logic [1:0] c_MODE_UP   = 2'b10;
    localparam logic [1:0] c_MODE_DOWN = 2'b11;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_ones_below;   // bit i: all bits below i are 1
    logic [WIDTH-1:0] w_zeros_below;  // bit i: all bits below i are 0

    // Bit 0 has no lower bits, so it always toggles when counting.
    assign w_ones_below[0]  = 1'b1;
    assign w_zeros_below[0] = 1'b1;

    generate
        for (genvar i = 1; i < WIDTH; i++) begin : g_chain
            assign w_ones_below[i]  = w_ones_below[i-1]  &  r_q[i-1];
            assign w_zeros_below[i] = w_zeros_below[i-1] & ~r_q[i-1];
        end
    endgenerate

    // Map every mode onto effective J/K inputs so one JK equation serves all.
    always_comb begin
        w_j = '0;
        w_k = '0;
        case (mode)
            c_MODE_JK: begin
                w_j = j;
                w_k = k;
            end
            c_MODE_LOAD: begin
                w_j = d;
                w_k = ~d;
            end
            c_MODE_UP: begin
                w_j = w_ones_below;
                w_k = w_ones_below;
            end
            c_MODE_DOWN: begin
                w_j = w_zeros_below;
                w_k = w_zeros_below;
            end
            default: begin
                w_j = '0;
                w_k = '0;
            end
        endcase
    end

    // JK characteristic equation per bit: Q+ = J&~Q | ~K&Q.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign w_q_next[i] = (w_j[i] & ~r_q[i]) | (~w_k[i] & r_q[i]);
        end
    endgenerate

    // State register: async reset dominates, enable gates every update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= RESET_VAL;
        end else if (en) begin
            r_q <= w_q_next;
        end
    end

    assign q  = r_q;
    assign qn = ~r_q;

    // Terminal count is suppressed while disabled or held in reset.
    assign tc = en & reset &
                (((mode == c_MODE_UP)   & (&r_q)) |
                 ((mode == c_MODE_DOWN) & ~(|r_q)));

endmodule
`default_nettype wire
